div_unit: RTL

Multi-cycle 32-bit integer divider in the EX stage. It serves DIV/DIVU/REM/REMU and drives the EX stall request into the stall controller. The stall controller answers that request with a 6'b001111 stall vector, which freezes the PC, IF, ID and EX until the quotient and remainder are ready. The algorithm is radix-2 restoring division, one bit per cycle, with RISC-V semantics for divide-by-zero and signed overflow.

---
 rtl/div_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit integer divider for the EX stage.
// Serves DIV/DIVU/REM/REMU using radix-2 restoring division, one quotient
// bit per cycle. It requests an EX stall while a divide is in flight, and
// follows RISC-V rules for divide-by-zero and signed overflow.
//
// Ports:
//   clk         core clock
//   rst         synchronous active-high reset
//   start_i     EX holds a divide (level, held while stalled)
//   signed_i    1 = DIV/REM, 0 = DIVU/REMU
//   dividend_i  rs1 value
//   divisor_i   rs2 value
//   annul_i     flush; aborts any operation in progress
//   stallreq_o  stall request to the stall controller (combinational)
//   ready_o     result valid this cycle
//   result_o    {remainder, quotient}, registered
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        annul_i,
  output logic        stallreq_o,
  output logic        ready_o,
  output logic [63:0] result_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic        neg_q;
  logic        neg_r;

  logic        accept;
  logic [31:0] dividend_mag;
  logic [31:0] divisor_mag;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic        ge;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign accept = (state == IDLE) && start_i && !annul_i;

  assign dividend_mag = (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
  assign divisor_mag  = (signed_i && divisor_i[31])  ? -divisor_i  : divisor_i;

  // Shift {R, Q} left by one. The shifted partial remainder needs 33 bits;
  // the borrow out of the subtraction doubles as the R >= divisor compare.
  // After a successful subtract R is below the divisor, so 32 bits of
  // storage are enough between iterations.
  assign rem_sh = {rem_q, quo_q[31]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign ge     = !diff[32];
  assign rem_nx = ge ? diff[31:0] : rem_sh[31:0];
  assign quo_nx = {quo_q[30:0], ge};

  assign quo_fix = neg_q ? -quo_nx : quo_nx;
  assign rem_fix = neg_r ? -rem_nx : rem_nx;

  assign stallreq_o = !annul_i && (((state == IDLE) && start_i) || (state == BUSY));
  assign ready_o    = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= 64'd0;
    end else if (annul_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            neg_q <= signed_i && (dividend_i[31] ^ divisor_i[31]);
            neg_r <= signed_i && dividend_i[31];
            dvs_q <= divisor_mag;
            quo_q <= dividend_mag;
            rem_q <= 32'd0;
            cnt   <= 5'd0;
            if (divisor_i == 32'd0) begin
              // Divide-by-zero: raw dividend as remainder, no sign correction.
              result_o <= {dividend_i, 32'hFFFF_FFFF};
              state    <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            result_o <= {rem_fix, quo_fix};
            state    <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
